frame_buffer_arbiter: RTL and testbench

//  Shares one single-port synchronous pixel RAM between the VGA scan-out reader
//  and the image processor writer. Display reads have strict priority and fixed

---
 rtl/frame_buffer_arbiter.sv | 114 +++++++++++
 tb/tb_frame_buffer_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: display reads (fixed 3-cycle latency, strict priority) and FIFO-buffered writes share one RAM port; define FBA_WR_FWD_EN to forward queued write data to reads
module frame_buffer_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rd_req,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [$clog2(WFIFO_DEPTH):0]   wfifo_lvl,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop, rd_p1, rd_p2;
    logic              ret_hit;
    logic [DATA_W-1:0] ret_data;

    assign wr_ready  = wfifo_lvl < LW'(WFIFO_DEPTH);
    assign push      = wr_valid && wr_ready;
    assign state_nxt = rd_req ? RD : (wfifo_lvl != '0 ? WR : IDLE);
    assign pop       = state_nxt == WR;
    assign mem_en    = state != IDLE;
    assign mem_we    = state == WR;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

`ifdef FBA_WR_FWD_EN
    logic              fwd_hit, hit1, hit2;
    logic [DATA_W-1:0] fwd_data, data1, data2;
    // Oldest first (the write on the RAM bus, then FIFO head to tail) so the newest match wins
    always_comb begin
        fwd_hit  = state == WR && mem_addr == rd_addr;
        fwd_data = mem_wdata;
        for (int i = 0; i < WFIFO_DEPTH; i++) begin
            if (LW'(i) < wfifo_lvl && fifo_addr[rd_ptr + PW'(i)] == rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[rd_ptr + PW'(i)];
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit1  <= 1'b0;
            hit2  <= 1'b0;
            data1 <= '0;
            data2 <= '0;
        end else begin
            hit1  <= rd_req && fwd_hit;
            hit2  <= hit1;
            data1 <= fwd_data;
            data2 <= data1;
        end
    end
    assign ret_hit  = hit2;
    assign ret_data = data2;
`else
    assign ret_hit  = 1'b0;
    assign ret_data = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wfifo_lvl <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_p1     <= 1'b0;
            rd_p2     <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr + PW'(push);
            rd_ptr    <= rd_ptr + PW'(pop);
            wfifo_lvl <= wfifo_lvl + LW'(push) - LW'(pop);
            if (rd_req)
                mem_addr <= rd_addr;
            else if (pop) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
            end
            rd_p1    <= rd_req;
            rd_p2    <= rd_p1;
            rd_valid <= rd_p2;
            if (rd_p2)
                rd_data <= ret_hit ? ret_data : mem_rdata;
        end
    end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed checks of read latency, write buffering, stalls, wrap and forwarding
module tb_frame_buffer_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_req = 1'b0;
    logic [16:0] rd_addr = '0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [16:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  wfifo_lvl;
    logic        mem_en, mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  ram [0:1023];
    int checks = 0;
    int errors = 0;

    frame_buffer_arbiter dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wfifo_lvl(wfifo_lvl), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr[9:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[9:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %0h exp 0", rd_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %0h exp 1", wr_ready); end
        checks++; if (wfifo_lvl !== 3'd0) begin errors++; $display("FAIL rst_lvl got %0h exp 0", wfifo_lvl); end
        checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL rst_mem_en_we got %0h exp 0", {mem_en, mem_we}); end
        checks++; if (mem_addr !== 17'd0) begin errors++; $display("FAIL rst_mem_addr got %0h exp 0", mem_addr); end
        reset = 1'b1;
        tick;
        rd_req = 1'b1; rd_addr = 17'd5;
        tick;
        rd_req = 1'b0;
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL midrd_issue got %0h exp 1", mem_en); end
        tick;
        reset = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL midrd_mem_en got %0h exp 0", mem_en); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midrd_wr_ready got %0h exp 1", wr_ready); end
        checks++; if (wfifo_lvl !== 3'd0) begin errors++; $display("FAIL midrd_lvl got %0h exp 0", wfifo_lvl); end
        tick;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrd_no_valid got %0h exp 0", rd_valid); end
        end
    endtask

    task automatic test_read_latency;
        wr_valid = 1'b1; wr_addr = 17'd10; wr_data = 8'h3C;
        tick;
        wr_valid = 1'b0;
        tick;
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 17'd10, 8'h3C}) begin errors++; $display("FAIL preload_wr got %0h exp %0h", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 17'd10, 8'h3C}); end
        tick;
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b00, 17'd10}) begin errors++; $display("FAIL idle_hold got %0h exp %0h", {mem_en, mem_we, mem_addr}, {2'b00, 17'd10}); end
        rd_req = 1'b1; rd_addr = 17'd10;
        tick;
        rd_req = 1'b0;
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 17'd10}) begin errors++; $display("FAIL rd_issue got %0h exp %0h", {mem_en, mem_we, mem_addr}, {2'b10, 17'd10}); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_early1 got %0h exp 0", rd_valid); end
        tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_early2 got %0h exp 0", rd_valid); end
        tick;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL rd_data got %0h exp %0h", {rd_valid, rd_data}, {1'b1, 8'h3C}); end
        tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse got %0h exp 0", rd_valid); end
    endtask

    task automatic test_stream_writes;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1; wr_addr = 17'(100 + k); wr_data = 8'(8'h10 + k);
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d got %0h exp 1", k, wr_ready); end
            tick;
            if (k >= 1) begin
                checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'(99 + k), 8'(8'h0F + k)}) begin errors++; $display("FAIL stream_wr k=%0d got %0h exp %0h", k, {mem_we, mem_addr, mem_wdata}, {1'b1, 17'(99 + k), 8'(8'h0F + k)}); end
            end
        end
        wr_valid = 1'b0;
        tick;
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'd104, 8'h14}) begin errors++; $display("FAIL stream_last got %0h exp %0h", {mem_we, mem_addr, mem_wdata}, {1'b1, 17'd104, 8'h14}); end
        tick;
        checks++; if ({mem_en, wfifo_lvl} !== {1'b0, 3'd0}) begin errors++; $display("FAIL stream_idle got %0h exp 0", {mem_en, wfifo_lvl}); end
    endtask

    task automatic test_full_stall;
        rd_req = 1'b1; rd_addr = 17'd10;
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1'b1; wr_addr = 17'(200 + k); wr_data = 8'(8'h50 + k);
            if (k < 4) tick;
        end
        checks++; if ({wr_ready, wfifo_lvl} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_ready_lvl got %0h exp %0h", {wr_ready, wfifo_lvl}, {1'b0, 3'd4}); end
        for (int i = 0; i < 20; i++) begin
            tick;
            checks++; if ({mem_we, wfifo_lvl} !== {1'b0, 3'd4}) begin errors++; $display("FAIL stall_i=%0d got %0h exp %0h", i, {mem_we, wfifo_lvl}, {1'b0, 3'd4}); end
        end
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL stall_rd got %0h exp %0h", {rd_valid, rd_data}, {1'b1, 8'h3C}); end
        rd_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (i == 0) begin
                checks++; if ({wr_ready, wfifo_lvl} !== {1'b1, 3'd3}) begin errors++; $display("FAIL full_pop_no_push got %0h exp %0h", {wr_ready, wfifo_lvl}, {1'b1, 3'd3}); end
            end
            if (i == 1) begin
                wr_valid = 1'b0;
                checks++; if (wfifo_lvl !== 3'd3) begin errors++; $display("FAIL held_beat_lvl got %0h exp 3", wfifo_lvl); end
            end
            checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'(200 + i), 8'(8'h50 + i)}) begin errors++; $display("FAIL drain_i=%0d got %0h exp %0h", i, {mem_we, mem_addr, mem_wdata}, {1'b1, 17'(200 + i), 8'(8'h50 + i)}); end
        end
        tick;
        checks++; if ({mem_en, wfifo_lvl} !== {1'b0, 3'd0}) begin errors++; $display("FAIL drain_done got %0h exp 0", {mem_en, wfifo_lvl}); end
    endtask

    task automatic test_wrap;
        rd_req = 1'b1; rd_addr = 17'd10;
        for (int k = 0; k < 11; k++) begin
            wr_valid = 1'b1; wr_addr = 17'(300 + k); wr_data = 8'(8'h80 + k);
            tick;
            if (k == 1) rd_req = 1'b0;
            if (k >= 2) begin
                checks++; if (wfifo_lvl !== 3'd2) begin errors++; $display("FAIL wrap_lvl k=%0d got %0h exp 2", k, wfifo_lvl); end
                checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'(298 + k), 8'(8'h7E + k)}) begin errors++; $display("FAIL wrap_wr k=%0d got %0h exp %0h", k, {mem_we, mem_addr, mem_wdata}, {1'b1, 17'(298 + k), 8'(8'h7E + k)}); end
            end
        end
        wr_valid = 1'b0;
        for (int k = 11; k < 13; k++) begin
            tick;
            checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'(298 + k), 8'(8'h7E + k)}) begin errors++; $display("FAIL wrap_tail k=%0d got %0h exp %0h", k, {mem_we, mem_addr, mem_wdata}, {1'b1, 17'(298 + k), 8'(8'h7E + k)}); end
        end
        tick;
        tick;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 7; k++) begin
            rd_req = k < 5; rd_addr = 17'(100 + k);
            tick;
            if (k >= 2) begin
                checks++; if ({rd_valid, rd_data} !== {1'b1, 8'(8'h0E + k)}) begin errors++; $display("FAIL b2b k=%0d got %0h exp %0h", k, {rd_valid, rd_data}, {1'b1, 8'(8'h0E + k)}); end
            end
        end
        rd_req = 1'b0;
        tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0h exp 0", rd_valid); end
    endtask

    task automatic test_forward;
        logic [7:0] exp_fwd;
`ifdef FBA_WR_FWD_EN
        exp_fwd = 8'hBB;
`else
        exp_fwd = 8'h11;
`endif
        wr_valid = 1'b1; wr_addr = 17'd7; wr_data = 8'h11;
        tick;
        wr_valid = 1'b0;
        tick; tick;
        rd_req = 1'b1; rd_addr = 17'd0;
        wr_valid = 1'b1; wr_data = 8'hAA;
        tick;
        wr_data = 8'hBB;
        tick;
        wr_valid = 1'b0; rd_addr = 17'd7;
        checks++; if (wfifo_lvl !== 3'd2) begin errors++; $display("FAIL fwd_queued got %0h exp 2", wfifo_lvl); end
        tick;
        rd_req = 1'b0;
        tick; tick;
        checks++; if ({rd_valid, rd_data} !== {1'b1, exp_fwd}) begin errors++; $display("FAIL fwd_rd got %0h exp %0h", {rd_valid, rd_data}, {1'b1, exp_fwd}); end
        tick; tick; tick;
        rd_req = 1'b1; rd_addr = 17'd7;
        tick;
        rd_req = 1'b0;
        tick; tick;
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hBB}) begin errors++; $display("FAIL fwd_after_drain got %0h exp %0h", {rd_valid, rd_data}, {1'b1, 8'hBB}); end
    endtask

    initial begin
        test_reset;
        test_read_latency;
        test_stream_writes;
        test_full_stall;
        test_wrap;
        test_back_to_back;
        test_forward;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
